axi_rd_arbiter_2x1: RTL and testbench

Arbitrates the AXI4 read address/data channels of the ICache (s0) and DCache (s1) masters onto one downstream read port. It is used as the read-side scheduler ahead of the shared memory interface. Exactly one burst is outstanding at a time. The block registers the granted AR request, then steers R beats back to the owner until the RLAST handshake. It checks each burst's beat count against ARLEN.

---
 rtl/axi_rd_arbiter_2x1.sv | 164 ++++++++++++++++
 tb/tb_axi_rd_arbiter_2x1.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter_2x1.sv
// Two-master AXI4 read arbiter: grants one AR at a time, registers it downstream,
// and steers R beats back to the owner until RLAST. It also flags bursts whose beat count disagrees with ARLEN.
module axi_rd_arbiter_2x1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  s0_ar_valid,
    output logic                  s0_ar_ready,
    input  logic [ADDR_WIDTH-1:0] s0_ar_addr,
    input  logic [7:0]            s0_ar_len,
    input  logic [2:0]            s0_ar_size,
    input  logic [1:0]            s0_ar_burst,
    input  logic [ID_WIDTH-1:0]   s0_ar_id,
    output logic                  s0_r_valid,
    input  logic                  s0_r_ready,
    output logic [DATA_WIDTH-1:0] s0_r_data,
    output logic [1:0]            s0_r_resp,
    output logic                  s0_r_last,
    output logic [ID_WIDTH-1:0]   s0_r_id,

    input  logic                  s1_ar_valid,
    output logic                  s1_ar_ready,
    input  logic [ADDR_WIDTH-1:0] s1_ar_addr,
    input  logic [7:0]            s1_ar_len,
    input  logic [2:0]            s1_ar_size,
    input  logic [1:0]            s1_ar_burst,
    input  logic [ID_WIDTH-1:0]   s1_ar_id,
    output logic                  s1_r_valid,
    input  logic                  s1_r_ready,
    output logic [DATA_WIDTH-1:0] s1_r_data,
    output logic [1:0]            s1_r_resp,
    output logic                  s1_r_last,
    output logic [ID_WIDTH-1:0]   s1_r_id,

    output logic                  m_ar_valid,
    input  logic                  m_ar_ready,
    output logic [ADDR_WIDTH-1:0] m_ar_addr,
    output logic [7:0]            m_ar_len,
    output logic [2:0]            m_ar_size,
    output logic [1:0]            m_ar_burst,
    output logic [ID_WIDTH-1:0]   m_ar_id,
    input  logic                  m_r_valid,
    output logic                  m_r_ready,
    input  logic [DATA_WIDTH-1:0] m_r_data,
    input  logic [1:0]            m_r_resp,
    input  logic                  m_r_last,
    input  logic [ID_WIDTH-1:0]   m_r_id,

    output logic                  busy,
    output logic                  grant,
    output logic                  len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t     state, state_nxt;
    logic       last_grant;
    logic [7:0] beat_cnt;
    logic       win_valid;
    logic       winner;
    logic       ar_hs;
    logic       r_hs;

    // Winner is only meaningful while win_valid; ties go by FIXED_PRIO or round-robin.
    always_comb begin
        win_valid = s0_ar_valid | s1_ar_valid;
        if (s0_ar_valid && s1_ar_valid)
            winner = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant;
        else
            winner = s1_ar_valid;
    end

    assign ar_hs = (state == IDLE) && win_valid;
    assign r_hs  = (state == DATA) && m_r_valid && m_r_ready;
    assign busy  = (state != IDLE);

    // Payload fans out to both masters; only the owner ever sees r_valid.
    assign s0_r_data = m_r_data;
    assign s0_r_resp = m_r_resp;
    assign s0_r_last = m_r_last;
    assign s0_r_id   = m_r_id;
    assign s1_r_data = m_r_data;
    assign s1_r_resp = m_r_resp;
    assign s1_r_last = m_r_last;
    assign s1_r_id   = m_r_id;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            m_ar_addr  <= '0;
            m_ar_len   <= '0;
            m_ar_size  <= '0;
            m_ar_burst <= '0;
            m_ar_id    <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            len_err    <= 1'b0;
        end else begin
            state   <= state_nxt;
            len_err <= 1'b0;
            if (ar_hs) begin
                m_ar_addr  <= winner ? s1_ar_addr  : s0_ar_addr;
                m_ar_len   <= winner ? s1_ar_len   : s0_ar_len;
                m_ar_size  <= winner ? s1_ar_size  : s0_ar_size;
                m_ar_burst <= winner ? s1_ar_burst : s0_ar_burst;
                m_ar_id    <= winner ? s1_ar_id    : s0_ar_id;
                grant      <= winner;
                last_grant <= winner;
                beat_cnt   <= '0;
            end
            if (r_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
                // RLAST must coincide exactly with beat index == len.
                if (m_r_last != (beat_cnt == m_ar_len))
                    len_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_valid)           state_nxt = ADDR;
            ADDR:    if (m_ar_ready)          state_nxt = DATA;
            DATA:    if (r_hs && m_r_last)    state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        s0_ar_ready = 1'b0;
        s1_ar_ready = 1'b0;
        s0_r_valid  = 1'b0;
        s1_r_valid  = 1'b0;
        m_ar_valid  = 1'b0;
        m_r_ready   = 1'b0;
        case (state)
            IDLE: begin
                s0_ar_ready = s0_ar_valid && !winner;
                s1_ar_ready = s1_ar_valid &&  winner;
            end
            ADDR: m_ar_valid = 1'b1;
            DATA: begin
                if (grant) begin
                    s1_r_valid = m_r_valid;
                    m_r_ready  = s1_r_ready;
                end else begin
                    s0_r_valid = m_r_valid;
                    m_r_ready  = s0_r_ready;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter_2x1.sv
// Directed bench for axi_rd_arbiter_2x1: a round-robin instance and a fixed-priority
// instance share all inputs; expected values are hand-computed per step.
module tb_axi_rd_arbiter_2x1;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  always #5 clk = ~clk;

  logic          s0_ar_valid, s1_ar_valid;
  logic [AW-1:0] s0_ar_addr, s1_ar_addr;
  logic [7:0]    s0_ar_len, s1_ar_len;
  logic [2:0]    s0_ar_size, s1_ar_size;
  logic [1:0]    s0_ar_burst, s1_ar_burst;
  logic [IW-1:0] s0_ar_id, s1_ar_id;
  logic          s0_r_ready, s1_r_ready;
  logic          m_ar_ready, m_r_valid, m_r_last;
  logic [DW-1:0] m_r_data;
  logic [1:0]    m_r_resp;
  logic [IW-1:0] m_r_id;

  logic          s0_ar_ready, s1_ar_ready, s0_r_valid, s1_r_valid;
  logic [DW-1:0] s0_r_data, s1_r_data;
  logic [1:0]    s0_r_resp, s1_r_resp;
  logic          s0_r_last, s1_r_last;
  logic [IW-1:0] s0_r_id, s1_r_id;
  logic          m_ar_valid, m_r_ready, busy, grant, len_err;
  logic [AW-1:0] m_ar_addr;
  logic [7:0]    m_ar_len;
  logic [2:0]    m_ar_size;
  logic [1:0]    m_ar_burst;
  logic [IW-1:0] m_ar_id;

  logic          p_s0_ar_ready, p_s1_ar_ready, p_s0_r_valid, p_s1_r_valid;
  logic [DW-1:0] p_s0_r_data, p_s1_r_data;
  logic [1:0]    p_s0_r_resp, p_s1_r_resp;
  logic          p_s0_r_last, p_s1_r_last;
  logic [IW-1:0] p_s0_r_id, p_s1_r_id;
  logic          p_m_ar_valid, p_m_r_ready, p_busy, p_grant, p_len_err;
  logic [AW-1:0] p_m_ar_addr;
  logic [7:0]    p_m_ar_len;
  logic [2:0]    p_m_ar_size;
  logic [1:0]    p_m_ar_burst;
  logic [IW-1:0] p_m_ar_id;

  axi_rd_arbiter_2x1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready), .s0_ar_addr(s0_ar_addr),
    .s0_ar_len(s0_ar_len), .s0_ar_size(s0_ar_size), .s0_ar_burst(s0_ar_burst), .s0_ar_id(s0_ar_id),
    .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready), .s0_r_data(s0_r_data),
    .s0_r_resp(s0_r_resp), .s0_r_last(s0_r_last), .s0_r_id(s0_r_id),
    .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready), .s1_ar_addr(s1_ar_addr),
    .s1_ar_len(s1_ar_len), .s1_ar_size(s1_ar_size), .s1_ar_burst(s1_ar_burst), .s1_ar_id(s1_ar_id),
    .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready), .s1_r_data(s1_r_data),
    .s1_r_resp(s1_r_resp), .s1_r_last(s1_r_last), .s1_r_id(s1_r_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last), .m_r_id(m_r_id),
    .busy(busy), .grant(grant), .len_err(len_err)
  );

  axi_rd_arbiter_2x1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .FIXED_PRIO(1)) dut_prio (
    .clk(clk), .rst(rst),
    .s0_ar_valid(s0_ar_valid), .s0_ar_ready(p_s0_ar_ready), .s0_ar_addr(s0_ar_addr),
    .s0_ar_len(s0_ar_len), .s0_ar_size(s0_ar_size), .s0_ar_burst(s0_ar_burst), .s0_ar_id(s0_ar_id),
    .s0_r_valid(p_s0_r_valid), .s0_r_ready(s0_r_ready), .s0_r_data(p_s0_r_data),
    .s0_r_resp(p_s0_r_resp), .s0_r_last(p_s0_r_last), .s0_r_id(p_s0_r_id),
    .s1_ar_valid(s1_ar_valid), .s1_ar_ready(p_s1_ar_ready), .s1_ar_addr(s1_ar_addr),
    .s1_ar_len(s1_ar_len), .s1_ar_size(s1_ar_size), .s1_ar_burst(s1_ar_burst), .s1_ar_id(s1_ar_id),
    .s1_r_valid(p_s1_r_valid), .s1_r_ready(s1_r_ready), .s1_r_data(p_s1_r_data),
    .s1_r_resp(p_s1_r_resp), .s1_r_last(p_s1_r_last), .s1_r_id(p_s1_r_id),
    .m_ar_valid(p_m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(p_m_ar_addr),
    .m_ar_len(p_m_ar_len), .m_ar_size(p_m_ar_size), .m_ar_burst(p_m_ar_burst), .m_ar_id(p_m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(p_m_r_ready), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last), .m_r_id(m_r_id),
    .busy(p_busy), .grant(p_grant), .len_err(p_len_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_g, exp_p;
    logic [IW-1:0] exp_id;
    int beat;

    rst = 1'b1;
    s0_ar_valid = 1'b0; s0_ar_addr = '0; s0_ar_len = '0; s0_ar_size = '0; s0_ar_burst = '0; s0_ar_id = '0;
    s1_ar_valid = 1'b0; s1_ar_addr = '0; s1_ar_len = '0; s1_ar_size = '0; s1_ar_burst = '0; s1_ar_id = '0;
    s0_r_ready = 1'b0; s1_r_ready = 1'b0;
    m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_last = 1'b0; m_r_data = '0; m_r_resp = '0; m_r_id = '0;
    step();
    step();

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_m_ar_valid", m_ar_valid, 1'b0);
    check("rst_m_ar_addr", m_ar_addr, 32'h0);
    check("rst_grant", grant, 1'b0);
    check("rst_m_r_ready", m_r_ready, 1'b0);
    check("rst_len_err", len_err, 1'b0);
    check("rst_s0_ar_ready", s0_ar_ready, 1'b0);
    rst = 1'b0;

    // 1: single s0 burst of 4 beats
    s0_ar_valid = 1'b1; s0_ar_addr = 32'h1C00_0000; s0_ar_len = 8'd3;
    s0_ar_size = 3'd2; s0_ar_burst = 2'd1; s0_ar_id = 4'd5;
    #1;
    check("t1_s0_ar_ready", s0_ar_ready, 1'b1);
    check("t1_s1_ar_ready", s1_ar_ready, 1'b0);
    check("t1_m_ar_valid_at_T", m_ar_valid, 1'b0);
    step();
    s0_ar_valid = 1'b0;
    #1;
    check("t1_m_ar_valid_T1", m_ar_valid, 1'b1);
    check("t1_m_ar_addr", m_ar_addr, 32'h1C00_0000);
    check("t1_m_ar_len", m_ar_len, 8'd3);
    check("t1_m_ar_size", m_ar_size, 3'd2);
    check("t1_m_ar_id", m_ar_id, 4'd5);
    check("t1_busy", busy, 1'b1);
    check("t1_grant", grant, 1'b0);
    check("t1_s0_ar_ready_addr", s0_ar_ready, 1'b0);
    m_ar_ready = 1'b1;
    step();
    m_ar_ready = 1'b0;
    #1;
    check("t1_m_ar_valid_data", m_ar_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      m_r_valid = 1'b1; m_r_data = 32'hA0 + 32'(i); m_r_id = 4'd5; m_r_last = (i == 3);
      s0_r_ready = 1'b1;
      #1;
      check("t1_s0_r_valid", s0_r_valid, 1'b1);
      check("t1_s0_r_data", s0_r_data, 32'hA0 + 32'(i));
      check("t1_s0_r_last", s0_r_last, (i == 3));
      check("t1_s0_r_id", s0_r_id, 4'd5);
      check("t1_s1_r_valid", s1_r_valid, 1'b0);
      check("t1_m_r_ready", m_r_ready, 1'b1);
      step();
      check("t1_len_err", len_err, 1'b0);
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;
    #1;
    check("t1_busy_after", busy, 1'b0);

    // 2+3: both masters held from reset; RR alternates, fixed-prio always picks s1
    rst = 1'b1;
    step();
    rst = 1'b0;
    s0_ar_id = 4'd1; s0_ar_len = 8'd0; s1_ar_id = 4'd2; s1_ar_len = 8'd0;
    s0_ar_valid = 1'b1; s1_ar_valid = 1'b1; s0_r_ready = 1'b1; s1_r_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) s1_ar_valid = 1'b0;
      exp_g  = (k == 4) ? 1'b0 : ((k % 2) == 1);
      exp_p  = (k == 4) ? 1'b0 : 1'b1;
      exp_id = exp_g ? 4'd2 : 4'd1;
      m_r_valid = 1'b0; m_r_last = 1'b0;
      #1;
      check("t2_gap_busy", busy, 1'b0);
      check("t2_s0_ar_ready", s0_ar_ready, !exp_g);
      check("t2_s1_ar_ready", s1_ar_ready, exp_g);
      check("t3_s0_ar_ready", p_s0_ar_ready, !exp_p);
      check("t3_s1_ar_ready", p_s1_ar_ready, exp_p);
      step();
      check("t2_grant", grant, exp_g);
      check("t2_m_ar_id", m_ar_id, exp_id);
      check("t3_grant", p_grant, exp_p);
      m_ar_ready = 1'b1;
      step();
      m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_last = 1'b1;
      #1;
      check("t2_owner_r_valid", exp_g ? s1_r_valid : s0_r_valid, 1'b1);
      check("t2_other_r_valid", exp_g ? s0_r_valid : s1_r_valid, 1'b0);
      step();
    end
    m_r_valid = 1'b0; m_r_last = 1'b0; s0_ar_valid = 1'b0;

    // 4: AR backpressure for 5 cycles, then toggling s1_r_ready
    s1_ar_valid = 1'b1; s1_ar_addr = 32'h0000_ABC0; s1_ar_len = 8'd3; s1_ar_id = 4'd3;
    #1;
    check("t4_s1_ar_ready", s1_ar_ready, 1'b1);
    step();
    s1_ar_valid = 1'b0; s1_ar_addr = 32'hDEAD_BEEF; s1_ar_len = 8'd77;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t4_m_ar_valid_hold", m_ar_valid, 1'b1);
      check("t4_m_ar_addr_hold", m_ar_addr, 32'h0000_ABC0);
      check("t4_m_ar_len_hold", m_ar_len, 8'd3);
      step();
    end
    m_ar_ready = 1'b1;
    step();
    m_ar_ready = 1'b0;
    beat = 0;
    for (int c = 0; c < 20 && beat < 4; c++) begin
      s1_r_ready = ((c % 2) == 0);
      m_r_valid = 1'b1; m_r_data = 32'h100 + 32'(beat); m_r_last = (beat == 3); m_r_id = 4'd3;
      #1;
      check("t4_s1_r_valid", s1_r_valid, 1'b1);
      check("t4_s1_r_data", s1_r_data, 32'h100 + 32'(beat));
      check("t4_m_r_ready", m_r_ready, s1_r_ready);
      check("t4_s0_r_valid", s0_r_valid, 1'b0);
      step();
      if (s1_r_ready) beat++;
      check("t4_len_err", len_err, 1'b0);
    end
    check("t4_beats_delivered", beat, 4);
    m_r_valid = 1'b0; m_r_last = 1'b0;
    #1;
    check("t4_busy_after", busy, 1'b0);

    // 5a: len=3, RLAST on 2nd beat
    s0_r_ready = 1'b1; s0_ar_len = 8'd3; s0_ar_id = 4'd4; s0_ar_valid = 1'b1;
    step();
    s0_ar_valid = 1'b0; m_ar_ready = 1'b1;
    step();
    m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_last = 1'b0;
    step();
    check("t5a_beat0_len_err", len_err, 1'b0);
    m_r_last = 1'b1;
    step();
    check("t5a_early_last_err", len_err, 1'b1);
    check("t5a_busy", busy, 1'b0);
    m_r_valid = 1'b0; m_r_last = 1'b0;
    step();
    check("t5a_pulse_end", len_err, 1'b0);

    // 5b: len=1, no RLAST on 2nd beat, RLAST on 3rd
    s0_ar_len = 8'd1; s0_ar_valid = 1'b1;
    step();
    s0_ar_valid = 1'b0; m_ar_ready = 1'b1;
    step();
    m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_last = 1'b0;
    step();
    check("t5b_beat0_len_err", len_err, 1'b0);
    step();
    check("t5b_missing_last_err", len_err, 1'b1);
    check("t5b_still_busy", busy, 1'b1);
    m_r_last = 1'b1;
    step();
    check("t5b_late_last_err", len_err, 1'b1);
    check("t5b_busy", busy, 1'b0);
    m_r_valid = 1'b0; m_r_last = 1'b0;
    step();
    check("t5b_pulse_end", len_err, 1'b0);

    // 6: reset mid-burst after one beat
    s0_ar_len = 8'd3; s0_ar_addr = 32'h1C00_0040; s0_ar_valid = 1'b1;
    step();
    s0_ar_valid = 1'b0; m_ar_ready = 1'b1;
    step();
    m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_last = 1'b0;
    step();
    check("t6_busy_mid", busy, 1'b1);
    rst = 1'b1;
    step();
    check("t6_busy", busy, 1'b0);
    check("t6_m_r_ready", m_r_ready, 1'b0);
    check("t6_s0_r_valid", s0_r_valid, 1'b0);
    check("t6_m_ar_valid", m_ar_valid, 1'b0);
    check("t6_m_ar_addr", m_ar_addr, 32'h0);
    check("t6_grant", grant, 1'b0);
    check("t6_len_err", len_err, 1'b0);
    rst = 1'b0; m_r_valid = 1'b0;
    s0_ar_addr = 32'h0000_2000; s0_ar_valid = 1'b1;
    #1;
    check("t6_new_s0_ar_ready", s0_ar_ready, 1'b1);
    step();
    s0_ar_valid = 1'b0;
    #1;
    check("t6_new_m_ar_valid", m_ar_valid, 1'b1);
    check("t6_new_m_ar_addr", m_ar_addr, 32'h0000_2000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
